aes_mem_seq: RTL
================

# aes_mem_seq

Memory-to-memory AES sequencer that sits between the data memory (`dmem`) and the AES round core used by the CPU's crypto extension. Given plaintext, key and destination word addresses, it fetches a 128-bit block and a 128-bit key from `dmem`, starts the AES core in encrypt or decrypt mode and writes the 128-bit result back to `dmem`. Its memory port is gated by an external grant, so a top-level mux can share `dmem` with the CPU.

## Interface
- `ADDR_W`, 32: width of all byte addresses.
- `TIMEOUT_CYCLES`, 64: maximum number of cycles to wait for `aes_done`. Used only with the watchdog compiled in.

- `clk`  in  1: clock. All registers use the rising edge.
- `reset_n`  in  1: asynchronous active-low reset.
- `start`  in  1: request a new operation. Sampled only in IDLE.
- `decrypt`  in  1: 0 = encrypt, 1 = decrypt. Latched on `start`.
- `src_addr`, `key_addr`, `dst_addr`  in  ADDR_W: byte addresses. Latched on `start`.
- `busy`  out  1: high while an operation is in flight.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: valid only with `done`. Set on a misaligned address or a timeout.
- `mem_gnt`  in  1: memory grant. An access counts only in a cycle where `mem_gnt` = 1.
- `mem_addr`  out  ADDR_W: word-aligned access address.
- `mem_read`  out  1: read strobe.
- `mem_write`  out  1: write strobe.
- `mem_wd`  out  32: write data.
- `mem_rd`  in  32: read data. Combinational; valid in the same cycle as `mem_read`.
- `aes_start`  out  1: one-cycle core start pulse.
- `aes_decrypt`  out  1: mode bit to the core.
- `aes_block_in`, `aes_key`  out  128: operands to the core. Held stable from `aes_start` until `aes_done`.
- `aes_done`  in  1: core completion pulse.
- `aes_block_out`  in  128: core result. Valid while `aes_done` = 1.

## Operation
- **States:** IDLE → LD_PT → LD_KEY → KICK → WAIT → ST_CT → DONE → IDLE.
- **Word counter:** 2 bits. Word k uses address base+4k. Word 0 maps to bits [127:96] and word 3 to bits [31:0]. Bytes within a word are passed unchanged.
- **IDLE:** `start` = 1 latches all inputs.
  - Any address with bits [1:0] ≠ 0 → go to DONE with `err` = 1. No memory access is issued.
  - Otherwise → LD_PT.
- **LD_PT / LD_KEY:** `mem_read` = 1 and `mem_addr` = base+4k.
  - When `mem_gnt` = 1: capture `mem_rd` into the block/key register and increment k.
  - When `mem_gnt` = 0: hold the access; k does not advance.
  - Leave each state after word 3 is captured.
- **KICK:** `aes_start` = 1 for exactly one cycle → WAIT.
- **WAIT:** on `aes_done` = 1, capture `aes_block_out` → ST_CT. `aes_done` seen in the KICK cycle is ignored.
- **ST_CT:** `mem_write` = 1, `mem_wd` = result word k, `mem_addr` = `dst_addr`+4k. k advances on `mem_gnt` as in the load states.
- **DONE:** `done` = 1 for one cycle → IDLE.
- **Start handling:** `start` while `busy` is ignored. `start` in the DONE cycle is ignored.
- **Overlapping buffers:** `mem_read` and `mem_write` are never high together. If `dst_addr` overlaps the source, the source is overwritten after it has been fully read.
- **Reset:** `reset_n` = 0 at any time → IDLE immediately. A partially written destination is left as is.

## Timing
- **Reset values:** all outputs are 0, including `mem_addr`, `mem_wd`, `aes_block_in` and `aes_key`.
- **Cycle numbering:** `start` is sampled at cycle 0, with `mem_gnt` held at 1.
  - Cycles 1–4: plaintext reads.
  - Cycles 5–8: key reads.
  - Cycle 9: `aes_start`.
  - `aes_done` arrives at cycle 9+N, with N ≥ 1.
  - Cycles 10+N to 13+N: writes.
  - Cycle 14+N: `done`.
- **Grant stalls:** each cycle with `mem_gnt` = 0 during LD_PT, LD_KEY or ST_CT adds exactly one cycle.
- **Busy:** high from cycle 1 through the last write. Low in the DONE cycle.
- **Misaligned start:** `done` and `err` at cycle 1, and `busy` never rises.

## Configuration
- **`AES_SEQ_TIMEOUT_EN` defined:** WAIT counts cycles.
  - If TIMEOUT_CYCLES cycles pass without `aes_done` → DONE with `err` = 1. No destination write is issued.
  - A late `aes_done` arriving in IDLE is ignored.
- **Not defined:** WAIT waits indefinitely, and `err` is raised only for misalignment.

## Test plan
- **Encrypt:** PT 00112233445566778899aabbccddeeff at 0x00, key 000102030405060708090a0b0c0d0e0f at 0x10, dst 0x20. AES core with N = 10. Required:
  - 0x20..0x2F = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - `done` at cycle 24 with `err` = 0.
- **Decrypt:** read CT from 0x20, write to 0x30. Required: 0x30..0x3F equals 0x00..0x0F.
- **Grant stalls:** toggle `mem_gnt` 1/0 every cycle during the same encrypt. Required:
  - Identical memory contents.
  - Latency extended by exactly the number of zero-grant cycles in access states.
  - Strobes and addresses are held while `mem_gnt` = 0.
- **Misaligned address:** `src_addr` = 0x02. Required: `done` and `err` at cycle 1, no `mem_read` or `mem_write`. `start` pulsed during a busy operation is ignored.
- **Reset mid-store:** assert `reset_n` = 0 after the second store. Required:
  - All outputs 0 immediately.
  - Only 0x20..0x27 written.
  - A new `start` completes normally.
- **Watchdog:** with `AES_SEQ_TIMEOUT_EN`, the core never asserts `aes_done`. Required:
  - `done` = 1 and `err` = 1 at cycle 9+64+1.
  - No writes are issued.

Source files
------------

// File: rtl/aes_mem_seq_if.sv
// aes_mem_seq_if: data-memory port and AES round-core handshake of the AES sequencer.
//
// master modport (sequencer side):
//   out: mem_addr, mem_read, mem_write, mem_wd   word access to dmem
//        aes_start, aes_decrypt, aes_block_in, aes_key   core command and operands
//   in : mem_gnt, mem_rd                         grant and combinational read data
//        aes_done, aes_block_out                 core completion and result
// slave modport: the same signals with the opposite directions (memory mux / core side).
interface aes_mem_seq_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;
    logic              aes_start;
    logic              aes_decrypt;
    logic [127:0]      aes_block_in;
    logic [127:0]      aes_key;
    logic              aes_done;
    logic [127:0]      aes_block_out;

    modport master (
        input  mem_gnt, mem_rd, aes_done, aes_block_out,
        output mem_addr, mem_read, mem_write, mem_wd,
        output aes_start, aes_decrypt, aes_block_in, aes_key
    );

    modport slave (
        output mem_gnt, mem_rd, aes_done, aes_block_out,
        input  mem_addr, mem_read, mem_write, mem_wd,
        input  aes_start, aes_decrypt, aes_block_in, aes_key
    );
endinterface

// File: rtl/aes_mem_seq.sv
// aes_mem_seq: memory-to-memory AES sequencer.
// Reads a 128-bit block and a 128-bit key from dmem (word k at base+4k, word 0 = bits
// [127:96]), starts the external AES core once and writes the 128-bit result to dmem.
// A dmem access completes only in a cycle with mem_gnt = 1, so the port can be shared.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   start, decrypt                 request and mode, latched in IDLE
//   src_addr, key_addr, dst_addr   byte addresses, must be word aligned
//   busy, done, err                status; err is only meaningful with the done pulse
//   bus (aes_mem_seq_if.master)    dmem port and AES core handshake
//
// Build option: define AES_SEQ_TIMEOUT_EN to give up with err = 1 when the core has not
// answered within TIMEOUT_CYCLES cycles of waiting.
module aes_mem_seq #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              decrypt,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] key_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    aes_mem_seq_if.master     bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLdPt,
        StLdKey,
        StKick,
        StWait,
        StStCt,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] kad_q, kad_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic              dec_q, dec_d;
    logic              err_q, err_d;
    logic [127:0]      blk_q, blk_d;
    logic [127:0]      key_q, key_d;
    logic [127:0]      res_q, res_d;
    logic [ADDR_W-1:0] word_off;
    logic              misaligned;

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WdW-1:0] wd_q, wd_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Word 0 lives in the most significant 32 bits of the 128-bit value.
    function automatic logic [127:0] put_word(input logic [127:0] v, input logic [1:0] k,
                                              input logic [31:0] w);
        logic [127:0] r;
        r = v;
        r[32*(3-int'(k)) +: 32] = w;
        return r;
    endfunction

    function automatic logic [31:0] get_word(input logic [127:0] v, input logic [1:0] k);
        return v[32*(3-int'(k)) +: 32];
    endfunction

    assign word_off   = ADDR_W'({cnt_q, 2'b00});
    assign misaligned = |{src_addr[1:0], key_addr[1:0], dst_addr[1:0]};

    // Operands come straight from the registers so they stay put while the core runs.
    assign bus.aes_decrypt  = dec_q;
    assign bus.aes_block_in = blk_q;
    assign bus.aes_key      = key_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            src_q   <= '0;
            kad_q   <= '0;
            dst_q   <= '0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
            blk_q   <= '0;
            key_q   <= '0;
            res_q   <= '0;
`ifdef AES_SEQ_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            kad_q   <= kad_d;
            dst_q   <= dst_d;
            dec_q   <= dec_d;
            err_q   <= err_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            res_q   <= res_d;
`ifdef AES_SEQ_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        kad_d   = kad_q;
        dst_d   = dst_q;
        dec_d   = dec_q;
        err_d   = err_q;
        blk_d   = blk_q;
        key_d   = key_q;
        res_d   = res_q;
`ifdef AES_SEQ_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        busy          = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_wd    = '0;
        bus.aes_start = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_d = src_addr;
                    kad_d = key_addr;
                    dst_d = dst_addr;
                    dec_d = decrypt;
                    cnt_d = '0;
                    err_d = misaligned;
                    // A bad address is reported without touching memory.
                    state_d = misaligned ? StDone : StLdPt;
                end
            end
            StLdPt: begin
                busy         = 1'b1;
                bus.mem_read = 1'b1;
                bus.mem_addr = src_q + word_off;
                if (bus.mem_gnt) begin
                    blk_d = put_word(blk_q, cnt_q, bus.mem_rd);
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = StLdKey;
                end
            end
            StLdKey: begin
                busy         = 1'b1;
                bus.mem_read = 1'b1;
                bus.mem_addr = kad_q + word_off;
                if (bus.mem_gnt) begin
                    key_d = put_word(key_q, cnt_q, bus.mem_rd);
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = StKick;
                end
            end
            StKick: begin
                busy          = 1'b1;
                bus.aes_start = 1'b1;
`ifdef AES_SEQ_TIMEOUT_EN
                wd_d          = '0;
`endif
                state_d       = StWait;
            end
            StWait: begin
                busy = 1'b1;
                if (bus.aes_done) begin
                    res_d   = bus.aes_block_out;
                    state_d = StStCt;
                end
`ifdef AES_SEQ_TIMEOUT_EN
                else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            StStCt: begin
                busy          = 1'b1;
                bus.mem_write = 1'b1;
                bus.mem_addr  = dst_q + word_off;
                bus.mem_wd    = get_word(res_q, cnt_q);
                if (bus.mem_gnt) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                err     = err_q;
                // start is not looked at here, so a request in this cycle is dropped.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
